// File: rtl/enc_pkg.sv
// Shared types, RV64I opcode/funct constants and per-format encoders for instr_encoder.
package enc_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_ANDI  = 4'd6,
        OP_ORI   = 4'd7,
        OP_XORI  = 4'd8,
        OP_JALR  = 4'd9,
        OP_JAL   = 4'd10,
        OP_BEQ   = 4'd11,
        OP_LUI   = 4'd12,
        OP_AUIPC = 4'd13,
        OP_LD    = 4'd14,
        OP_SD    = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } cmd_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_DW   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:12] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    endfunction

    // Immediates are truncated to the bits each format carries.
    function automatic logic [31:0] encode(input cmd_t c);
        logic [31:0] w;
        w = NOP_WORD;
        case (c.op)
            OP_ADD:   w = enc_r(F7_BASE, c.rs2, c.rs1, F3_ADD, c.rd, OPC_OP);
            OP_SUB:   w = enc_r(F7_SUB,  c.rs2, c.rs1, F3_ADD, c.rd, OPC_OP);
            OP_AND:   w = enc_r(F7_BASE, c.rs2, c.rs1, F3_AND, c.rd, OPC_OP);
            OP_OR:    w = enc_r(F7_BASE, c.rs2, c.rs1, F3_OR,  c.rd, OPC_OP);
            OP_XOR:   w = enc_r(F7_BASE, c.rs2, c.rs1, F3_XOR, c.rd, OPC_OP);
            OP_ADDI:  w = enc_i(c.imm[11:0], c.rs1, F3_ADD, c.rd, OPC_OP_IMM);
            OP_ANDI:  w = enc_i(c.imm[11:0], c.rs1, F3_AND, c.rd, OPC_OP_IMM);
            OP_ORI:   w = enc_i(c.imm[11:0], c.rs1, F3_OR,  c.rd, OPC_OP_IMM);
            OP_XORI:  w = enc_i(c.imm[11:0], c.rs1, F3_XOR, c.rd, OPC_OP_IMM);
            OP_JALR:  w = enc_i(c.imm[11:0], c.rs1, F3_JALR, c.rd, OPC_JALR);
            OP_JAL:   w = enc_j(c.imm[20:1], c.rd, OPC_JAL);
            OP_BEQ:   w = enc_b(c.imm[12:1], c.rs2, c.rs1, F3_BEQ, OPC_BRANCH);
            OP_LUI:   w = enc_u(c.imm[31:12], c.rd, OPC_LUI);
            OP_AUIPC: w = enc_u(c.imm[31:12], c.rd, OPC_AUIPC);
            OP_LD:    w = enc_i(c.imm[11:0], c.rs1, F3_DW, c.rd, OPC_LOAD);
            OP_SD:    w = enc_s(c.imm[11:0], c.rs2, c.rs1, F3_DW, OPC_STORE);
            default:  w = NOP_WORD;
        endcase
        return w;
    endfunction

    // True when the immediate fits its format exactly and the op is known.
    function automatic logic imm_ok(input cmd_t c);
        logic signed [31:0] s;
        logic ok;
        s  = $signed(c.imm);
        ok = 1'b0;
        case (c.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                ok = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_JALR, OP_LD, OP_SD:
                ok = (s >= -32'sd2048) && (s <= 32'sd2047);
            OP_BEQ:
                ok = (s >= -32'sd4096) && (s <= 32'sd4094) && !c.imm[0];
            OP_JAL:
                ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && !c.imm[0];
            OP_LUI, OP_AUIPC:
                ok = (c.imm[11:0] == 12'h000);
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Power-of-two FIFO with extra-bit pointers; caller never pushes when full or pops when empty.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop)  rptr <= rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= push_data;
    end

    assign pop_data = mem[rptr[PW-1:0]];
    assign empty    = (wptr == rptr);
    assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction commands into RV64I words, buffers them and writes them to imem.
// Optional ENC_RANGE_CHK_EN: reject out-of-range immediates / unknown ops with an err pulse.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = AW'(32'h8000_0000)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          done,
    output logic          err
);
    state_e      state;
    state_e      state_next;
    cmd_t        cmd;
    logic [31:0] word;
    logic        bad;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    assign cmd = '{op: op_e'(in_op), rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    assign word = encode(cmd);
`ifdef ENC_RANGE_CHK_EN
    assign bad = !imm_ok(cmd);
`else
    assign bad = 1'b0;
`endif
    assign accept = in_valid && in_ready;
    assign push   = accept && !bad;
    assign pop    = wr_en && wr_ready;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (wr_data),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)  state_next = ST_RUN;
            ST_RUN:   if (finish) state_next = ST_DRAIN;
            ST_DRAIN: if (empty)  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decode only flops, so wr_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready = !full;
                wr_en    = !empty;
            end
            ST_DRAIN: wr_en = !empty;
            ST_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= BASE_ADDR;
            err     <= 1'b0;
        end else begin
            err <= accept && bad;
            if (state == ST_IDLE && start) wr_addr <= BASE_ADDR;
            else if (pop)                  wr_addr <= wr_addr + AW'(4);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, backpressure, drain and random commands.
`timescale 1ns/1ps
module tb_instr_encoder;
    import enc_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int FR = 0, FI = 1, FS = 2, FB = 3, FU = 4, FJ = 5, FX = 6;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid, in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        wr_en, wr_ready, done, err;
    logic [31:0] wr_addr, wr_data;

    typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
    exp_t        sb[$];
    logic [31:0] next_addr;
    int          vectors = 0;
    int          miscompares = 0;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: RISC-V field placement from the format rules, using shifts and masks.
    function automatic void model(input op_e op, input int unsigned rd, input int unsigned rs1,
                                  input int unsigned rs2, input logic [31:0] imm,
                                  output logic [31:0] w, output bit legal);
        int unsigned u, opc, f3, f7;
        int s, fmt;
        u = imm; s = int'(imm); f3 = 0; f7 = 0; opc = 0; fmt = FX;
        case (op)
            OP_ADD:   begin fmt = FR; opc = 'h33; f3 = 0; end
            OP_SUB:   begin fmt = FR; opc = 'h33; f3 = 0; f7 = 'h20; end
            OP_AND:   begin fmt = FR; opc = 'h33; f3 = 7; end
            OP_OR:    begin fmt = FR; opc = 'h33; f3 = 6; end
            OP_XOR:   begin fmt = FR; opc = 'h33; f3 = 4; end
            OP_ADDI:  begin fmt = FI; opc = 'h13; f3 = 0; end
            OP_ANDI:  begin fmt = FI; opc = 'h13; f3 = 7; end
            OP_ORI:   begin fmt = FI; opc = 'h13; f3 = 6; end
            OP_XORI:  begin fmt = FI; opc = 'h13; f3 = 4; end
            OP_JALR:  begin fmt = FI; opc = 'h67; f3 = 0; end
            OP_JAL:   begin fmt = FJ; opc = 'h6f; end
            OP_BEQ:   begin fmt = FB; opc = 'h63; f3 = 0; end
            OP_LUI:   begin fmt = FU; opc = 'h37; end
            OP_AUIPC: begin fmt = FU; opc = 'h17; end
            OP_LD:    begin fmt = FI; opc = 'h03; f3 = 3; end
            OP_SD:    begin fmt = FS; opc = 'h23; f3 = 3; end
            default:  fmt = FX;
        endcase
        case (fmt)
            FR: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
            FI: w = ((u % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
            FS: w = (((u >> 5) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((u % 32) << 7) | opc;
            FB: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 15) << 8)
                    | (((u >> 11) & 1) << 7) | opc;
            FU: w = (u & 32'hFFFF_F000) | (rd << 7) | opc;
            FJ: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21)
                    | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | (rd << 7) | opc;
            default: w = 32'h0000_0013;
        endcase
`ifdef ENC_RANGE_CHK_EN
        case (fmt)
            FR:      legal = 1;
            FI, FS:  legal = (s >= -2048) && (s <= 2047);
            FB:      legal = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            FJ:      legal = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
            FU:      legal = (u % 4096 == 0);
            default: legal = 0;
        endcase
`else
        legal = 1;
`endif
    endfunction

    // Monitor: every accepted imem write must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && wr_en && wr_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%h data 0x%h, want none", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    task automatic send(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input bit use_lit, input logic [31:0] lit, input bit rnd_rdy);
        logic [31:0] w;
        bit legal, got;
        model(op, rd, rs1, rs2, imm, w, legal);
        if (use_lit) w = lit;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                if (legal) begin
                    sb.push_back('{addr: next_addr, data: w});
                    next_addr += 32'd4;
                end
            end
            @(posedge clk); #1;
            if (rnd_rdy) wr_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!got) timeout("send_accept");
        else begin
            @(negedge clk);
            check("err", 64'(err), 64'(!legal));
            @(posedge clk); #1;
        end
    endtask

    task automatic gen_cmd(input bit allow_bad, output op_e op, output logic [4:0] rd,
                           output logic [4:0] rs1, output logic [4:0] rs2, output logic [31:0] imm);
        op  = op_e'($urandom_range(0, 15));
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        if (allow_bad && $urandom_range(0, 5) == 0) imm = $urandom;
        else case (op)
            OP_BEQ:           imm = 32'($urandom_range(0, 4095) * 2) - 32'd4096;
            OP_JAL:           imm = 32'($urandom_range(0, 1048575) * 2) - 32'd1048576;
            OP_LUI, OP_AUIPC: imm = $urandom & 32'hFFFF_F000;
            default:          imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endtask

    task automatic send_rand(input bit allow_bad, input bit rnd_rdy);
        op_e op; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
        gen_cmd(allow_bad, op, rd, rs1, rs2, imm);
        send(op, rd, rs1, rs2, imm, 0, 32'h0, rnd_rdy);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        next_addr = BASE;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1;
        end
        if (!ok) timeout("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] hold_addr, hold_data;
        bit seen;
        reset = 1'b1; start = 0; finish = 0; in_valid = 0; wr_ready = 0;
        in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; next_addr = BASE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(BASE));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;

        // Directed encodings from known assembler output.
        do_start();
        wr_ready = 1'b1;
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 32'hFFF00093, 0);
        send(OP_SD, 5'd0, 5'd2, 5'd5, 32'd8, 1, 32'h00513423, 0);
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 32'hFE208EE3, 0);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h001000EF, 0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h80000093, 0);
        wait_drain();

        // Backpressure: four queued words fill the FIFO and hold the write port steady.
        wr_ready = 1'b0;
        repeat (4) send_rand(0, 0);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("stall_wr_en", 64'(wr_en), 64'(1));
        hold_addr = wr_addr; hold_data = wr_data;
        repeat (3) @(negedge clk);
        check("stall_addr", 64'(wr_addr), 64'(hold_addr));
        check("stall_data", 64'(wr_data), 64'(hold_data));
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_drain();

        // Random commands with random write backpressure.
        for (int n = 0; n < 200; n++) send_rand(1, 1);
        wr_ready = 1'b1;
        wait_drain();

        // Finish with two words queued: both written, then a single done pulse.
        wr_ready = 1'b0;
        repeat (2) send_rand(0, 0);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        check("drain_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        wr_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) timeout("done_pulse");
        else begin
            check("done_sb_empty", 64'(sb.size()), 64'(0));
            @(negedge clk);
            check("done_width", 64'(done), 64'(0));
            check("idle_after_done", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;

        // Reset in RUN drops queued words and restores the base address.
        do_start();
        wr_ready = 1'b0;
        repeat (2) send_rand(0, 0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_wr_en", 64'(wr_en), 64'(0));
            check("post_rst_in_ready", 64'(in_ready), 64'(0));
        end
        check("post_rst_addr", 64'(wr_addr), 64'(BASE));
        @(posedge clk); #1;
        do_start();
        send(OP_LUI, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1, 32'h123453B7, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
